keypad_matrix_emulator: RTL and testbench

Drives the row lines of a 4x4 matrix keypad in response to the column scan from the keypad scanner. Key presses arrive as 4-bit codes over a valid/ready handshake and are buffered in a small FIFO. Each press is replayed as a timed press/hold/release sequence. The block is used for hardware-in-loop and regression of the vending machine without a physical keypad.

---
 rtl/keypad_matrix_emulator_if.sv | 9 +
 rtl/keypad_matrix_emulator.sv | 142 ++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_emulator_if.sv
// Key-code push handshake between a stimulus source and the keypad emulator.
interface keypad_matrix_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 keypad emulator: queued key codes replayed as timed press/release on the row lines.
// Optional contact bounce via LFSR when KEYEMU_BOUNCE_EN is defined.
module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES   = 2000,
    parameter int GAP_CYCLES    = 1000,
    parameter int FIFO_DEPTH    = 4,
    parameter int BOUNCE_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    shift_col,
    output logic [3:0]                    row,
    keypad_matrix_emulator_if.slave       kif,
    output logic                          key_active,
    output logic [3:0]                    active_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXC  = (MAXHG > BOUNCE_CYCLES) ? MAXHG : BOUNCE_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_t;

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE} state_t;

    state_t                          state, state_nx;
    logic [CW-1:0]                   cnt;
    logic                            cnt_zero;
    logic [FIFO_DEPTH-1:0][3:0]      mem;
    logic [AW-1:0]                   wr_ptr, rd_ptr;
    logic                            push, pop;
    logic                            contact;
    logic [3:0]                      row_nx;
    key_t                            act_key;

    // ---------------- FIFO ----------------
    assign kif.key_ready = (fifo_count < DEPTH_V);
    assign push          = kif.key_valid & kif.key_ready;
    assign pop           = (state == S_IDLE) && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= kif.key_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- FSM ----------------
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (pop)      state_nx = S_PRESS;
            S_PRESS:   if (cnt_zero) state_nx = S_RELEASE;
            S_RELEASE: if (cnt_zero) state_nx = S_IDLE;
            default:                 state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        key_active = (state == S_PRESS);
        busy       = (state != S_IDLE) || (fifo_count != '0);
    end

    // Counter reloads on every state entry, so it never needs to wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            active_code <= '0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    cnt         <= HOLD_LD;
                    active_code <= mem[rd_ptr];
                end
                S_PRESS:   cnt <= cnt_zero ? GAP_LD : cnt - 1'b1;
                S_RELEASE: if (!cnt_zero) cnt <= cnt - 1'b1;
                default:   cnt <= '0;
            endcase
        end
    end

    // ---------------- contact model ----------------
`ifdef KEYEMU_BOUNCE_EN
    localparam logic [CW-1:0] HOLD_BW = CW'(HOLD_CYCLES - BOUNCE_CYCLES);
    localparam logic [CW-1:0] GAP_BW  = CW'(GAP_CYCLES - BOUNCE_CYCLES);
    logic [7:0] lfsr;
    logic       in_bounce;

    // x^8+x^6+x^5+x^4+1, free-running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Counter starts at LD and counts down, so the first BOUNCE cycles are cnt >= LD+1-BOUNCE.
    assign in_bounce = ((state == S_PRESS)   && (cnt >= HOLD_BW)) ||
                       ((state == S_RELEASE) && (cnt >= GAP_BW));
    assign contact   = in_bounce ? lfsr[0] : key_active;
`else
    assign contact   = key_active;
`endif

    // ---------------- row generation ----------------
    assign act_key = key_t'(active_code);

    for (genvar g = 0; g < 4; g++) begin : g_row
        assign row_nx[g] = ~(contact && (act_key.row == 2'(g)) && !shift_col[act_key.col]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) row <= 4'hF;
        else        row <= row_nx;
    end
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with a press-order scoreboard.
module tb_keypad_matrix_emulator;
    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] shift_col = 4'hF;
    logic [3:0] row, active_code;
    logic       key_active, busy;
    logic [2:0] fifo_count;

    keypad_matrix_emulator_if kif();

    keypad_matrix_emulator #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .BOUNCE_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .shift_col(shift_col), .row(row), .kif(kif),
        .key_active(key_active), .active_code(active_code),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic       act_prev = 1'b0;
    logic [3:0] exp_q[$];
    int         rise_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; on every press start, the scoreboard head must be the pressed code.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (key_active === 1'b1 && act_prev !== 1'b1) begin
            rise_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_press", {28'd0, active_code}, 32'hFFFF_FFFF);
            else                   check("press_code", {28'd0, active_code}, {28'd0, exp_q.pop_front()});
        end
        act_prev = key_active;
    endtask

    task automatic push(input logic [3:0] c);
        kif.key_valid = 1'b1;
        kif.key_code  = c;
        exp_q.push_back(c);
        step();
        kif.key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0] sweep [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] qc [6]    = '{4'h1, 4'h5, 4'h9, 4'hA, 4'hE, 4'h3};
        logic       exp_act, exp_act_prev;
        logic [3:0] sc;

        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;

        // Reset state
        step(); step();
        check("rst_row", row, 4'hF);
        check("rst_ready", kif.key_ready, 1);
        check("rst_active", key_active, 0);
        check("rst_code", active_code, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        step();

        // Single key 6 (col 1, row 2) with sweeping columns
        push(4'h6);
        exp_act_prev = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            sc = sweep[((k - 1) / 4) % 4];
            shift_col = sc;
            step();
            exp_act = (k <= HOLD);
            check("t1_active", key_active, exp_act);
            check("t1_row", row, (exp_act_prev && !sc[1]) ? 4'b1011 : 4'hF);
            exp_act_prev = exp_act;
        end
        shift_col = 4'hF;
        wait_idle("t1_idle", 20);

        // Queue full: five accepted, sixth refused, replay period HOLD+GAP+1
        rise_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            kif.key_valid = 1'b1;
            kif.key_code  = qc[i];
            check("t2_ready", kif.key_ready, (i < 5) ? 1 : 0);
            if (i < 5) exp_q.push_back(qc[i]);
            step();
        end
        kif.key_valid = 1'b0;
        check("t2_count_full", fifo_count, 4);
        check("t2_ready_low", kif.key_ready, 0);
        wait_idle("t2_idle", 120);
        check("t2_presses", rise_cyc.size(), 5);
        for (int i = 1; i < 5 && i < rise_cyc.size(); i++)
            check("t2_period", rise_cyc[i] - rise_cyc[i-1], HOLD + GAP + 1);
        check("t2_drained", exp_q.size(), 0);

        // Idle columns, then column 3 driven during press of code F
        shift_col = 4'hF;
        push(4'hF);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t3_row_idle", row, 4'hF);
        end
        shift_col = 4'b0111;
        step();
        check("t3_row_col3", row, 4'b0111);
        shift_col = 4'hF;
        wait_idle("t3_idle", 30);

        // All columns driven, then reset mid-press with two codes queued
        shift_col = 4'b0000;
        push(4'h0);
        push(4'h4);
        push(4'h8);
        check("t4_row_multi", row, 4'b1110);
        check("t4_count", fifo_count, 2);
        check("t4_active", key_active, 1);
        reset = 1'b0;
        #1;
        check("t4_rst_row", row, 4'hF);
        check("t4_rst_count", fifo_count, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_active", key_active, 0);
        check("t4_rst_ready", kif.key_ready, 1);
        exp_q.delete();
        act_prev = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("t4_quiet", {row, busy, key_active}, {4'hF, 1'b0, 1'b0});
        end
        push(4'h7);
        wait_idle("t4_idle", 30);
        check("t4_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
